// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and input code constants for the round game
package game_pkg;

    localparam int CODE_W = 3;

    localparam logic [CODE_W-1:0] CODE_NONE   = 3'd0;
    localparam logic [CODE_W-1:0] CODE_TOGGLE = 3'd1;
    localparam logic [CODE_W-1:0] CODE_PUSH   = 3'd2;
    localparam logic [CODE_W-1:0] CODE_MIC    = 3'd3;
    localparam logic [CODE_W-1:0] CODE_MOUSE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4,
        ST_OVER = 3'd5
    } state_t;

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - round countdown in timebase ticks; a count of zero never decrements
module round_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       enable,
    input  logic       tick,
    output logic [7:0] count,
    output logic       expire
);
    import game_pkg::*;

    // Untimed rounds load zero, so the nonzero guard keeps them frozen.
    assign expire = enable && tick && (count == 8'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && tick && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - matches input codes against a target sequence under a tick countdown
module round_sequencer #(
    parameter int MAX_LEN = 8,
    parameter int LIVES   = 3,
    parameter int CODE_W  = game_pkg::CODE_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      tick,
    input  logic [CODE_W-1:0]         in_code,
    input  logic [CODE_W*MAX_LEN-1:0] target_seq,
    input  logic [3:0]                target_len,
    input  logic [7:0]                time_limit,
    output logic [2:0]                state,
    output logic [3:0]                progress,
    output logic [7:0]                time_left,
    output logic [1:0]                lives,
    output logic [7:0]                score,
    output logic                      round_pass,
    output logic                      round_fail,
    output logic                      game_over,
    output logic                      str_clr
);
    import game_pkg::*;

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    state_t                    state_q, state_d;
    logic [CODE_W*MAX_LEN-1:0] seq_q;
    logic [3:0]                len_q, progress_d;
    logic [CODE_W-1:0]         cur_elem;
    logic                      len_ok, hit, miss, timer_load, timer_en, expire;

    always_comb begin
        cur_elem = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (progress == 4'(i)) cur_elem = seq_q[i*CODE_W +: CODE_W];
        end
    end

    assign len_ok     = (target_len != 4'd0) && (target_len <= MAX_LEN_L);
    assign hit        = (state_q == ST_PLAY) && (in_code != '0) && (in_code == cur_elem);
    assign miss       = (state_q == ST_PLAY) && (in_code != '0) && (in_code != cur_elem);
    assign timer_load = (state_q == ST_LOAD) && len_ok;
    // A wrong code freezes the countdown for that cycle even if a tick arrives.
    assign timer_en   = (state_q == ST_PLAY) && !miss;
    assign state      = state_q;

    round_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (time_limit),
        .enable     (timer_en),
        .tick       (tick),
        .count      (time_left),
        .expire     (expire)
    );

    always_comb begin
        state_d    = state_q;
        progress_d = progress;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (len_ok) begin
                    progress_d = 4'd0;
                    state_d    = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    state_d = ST_FAIL;
                end else begin
                    if (hit) progress_d = progress + 4'd1;
                    // A completing match beats an expiring tick in the same cycle.
                    if (hit && (progress + 4'd1 == len_q)) state_d = ST_PASS;
                    else if (expire)                       state_d = ST_FAIL;
                end
            end
            ST_PASS: state_d = ST_IDLE;
            ST_FAIL: state_d = (lives == 2'd1) ? ST_OVER : ST_IDLE;
            ST_OVER: if (start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            progress   <= 4'd0;
            seq_q      <= '0;
            len_q      <= 4'd0;
            lives      <= 2'(LIVES);
            score      <= 8'd0;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            game_over  <= 1'b0;
            str_clr    <= 1'b0;
        end else begin
            state_q  <= state_d;
            progress <= progress_d;
            if (timer_load) begin
                seq_q <= target_seq;
                len_q <= target_len;
            end
            if ((state_q == ST_PASS) && (score != 8'hff)) score <= score + 8'd1;
            if (state_q == ST_FAIL) lives <= lives - 2'd1;
            if ((state_q == ST_OVER) && start) begin
                lives <= 2'(LIVES);
                score <= 8'd0;
            end
            round_pass <= (state_d == ST_PASS);
            round_fail <= (state_d == ST_FAIL);
            game_over  <= (state_d == ST_OVER);
            str_clr    <= (state_d == ST_LOAD);
        end
    end

endmodule
